// File: rtl/sample_out_fifo_if.sv
// Stereo sample FIFO bundle: producer strobe side, FWFT consumer side, drop status.
// Producer/consumer drive the master modport; the FIFO takes the slave modport.
interface sample_out_fifo_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 4
);
  logic                             in_valid;
  logic signed [SAMPLE_WIDTH-1:0]   in_l;
  logic signed [SAMPLE_WIDTH-1:0]   in_r;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [SAMPLE_WIDTH-1:0]   out_l;
  logic signed [SAMPLE_WIDTH-1:0]   out_r;
  logic [$clog2(DEPTH):0]           level;
  logic                             overflow;
  logic                             overflow_clr;
  logic [7:0]                       drop_count;

  modport master (
    output in_valid, in_l, in_r, out_ready, overflow_clr,
    input  out_valid, out_l, out_r, level, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_l, in_r, out_ready, overflow_clr,
    output out_valid, out_l, out_r, level, overflow, drop_count
  );
endinterface

// File: rtl/sample_out_fifo.sv
// Stereo pair FIFO, first-word-fall-through (1-cycle push-to-out latency), holds last popped pair when empty.
// No input backpressure: a strobe while full without a pop is dropped and counted; output uses valid/ready.
module sample_out_fifo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  sample_out_fifo_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] l;
    logic [SAMPLE_WIDTH-1:0] r;
  } pair_t;

  pair_t         mem_q [DEPTH];
  pair_t         mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  pair_t         last_q, last_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  pair_t         head;

  always_comb begin
    full         = (level_q == DEPTH_L);
    pop          = (level_q != '0) && bus.out_ready;
    push         = bus.in_valid && (!full || pop);
    drop         = bus.in_valid && !push;

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    last_d       = last_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{l: bus.in_l, r: bus.in_r};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the clear cycle restarts the count at one rather than zero.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.overflow_clr)
        drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF)
        drop_count_d = drop_count_q + 8'd1;
    end else if (bus.overflow_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end

    head = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_q       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is left unreset; stale entries are unreachable once level is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid  = (level_q != '0);
  assign bus.out_l      = head.l;
  assign bus.out_r      = head.r;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_sample_out_fifo.sv
// Randomized and directed bench for sample_out_fifo against a queue-based reference model.
module tb_sample_out_fifo;
  localparam int W = 16;
  localparam int D = 4;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  sample_out_fifo_if #(.SAMPLE_WIDTH(W), .DEPTH(D)) bus ();

  sample_out_fifo #(.SAMPLE_WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {l,r} pairs plus status.
  logic [31:0] q_m[$];
  logic [31:0] last_m;
  logic        ovf_m;
  int          dc_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    last_m = 32'd0;
    ovf_m  = 1'b0;
    dc_m   = 0;
  endtask

  task automatic check_model();
    logic [31:0] head;
    head = (q_m.size() != 0) ? q_m[0] : last_m;
    check("out_valid", 32'(bus.out_valid), 32'(q_m.size() != 0));
    check("out_pair", {bus.out_l, bus.out_r}, head);
    check("level", 32'(bus.level), 32'(q_m.size()));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    check("drop_count", 32'(bus.drop_count), 32'(dc_m));
  endtask

  task automatic model_update(input logic iv, input logic [31:0] pair, input logic rdy, input logic clr);
    logic pop;
    logic acc;
    pop = (q_m.size() != 0) && rdy;
    acc = iv && ((q_m.size() < D) || pop);
    if (pop) last_m = q_m.pop_front();
    if (acc) q_m.push_back(pair);
    if (iv && !acc) begin
      ovf_m = 1'b1;
      dc_m  = clr ? 1 : ((dc_m < 255) ? dc_m + 1 : 255);
    end else if (clr) begin
      ovf_m = 1'b0;
      dc_m  = 0;
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] l, input logic [15:0] r,
                      input logic rdy, input logic clr);
    @(negedge clk);
    check_model();
    bus.in_valid     = iv;
    bus.in_l         = l;
    bus.in_r         = r;
    bus.out_ready    = rdy;
    bus.overflow_clr = clr;
    model_update(iv, {l, r}, rdy, clr);
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_l         = '0;
    bus.in_r         = '0;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = 1'b0;
    model_reset();

    #2;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", {bus.out_l, bus.out_r}, 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_dc", 32'(bus.drop_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single push, FWFT with one cycle latency.
    step(1'b1, 16'h1234, 16'hFEDC, 1'b0, 1'b0);
    check("fwft_valid", 32'(bus.out_valid), 32'd1);
    check("fwft_pair", {bus.out_l, bus.out_r}, 32'h1234FEDC);
    check("fwft_level", 32'(bus.level), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Five pushes into four entries.
    for (int i = 1; i <= 5; i++)
      step(1'b1, 16'(16'h0A00 + i), 16'(16'h0B00 + i), 1'b0, 1'b0);
    check("ovf5_level", 32'(bus.level), 32'd4);
    check("ovf5_flag", 32'(bus.overflow), 32'd1);
    check("ovf5_dc", 32'(bus.drop_count), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf5_order", {bus.out_l, bus.out_r}, {16'(16'h0A00 + i), 16'(16'h0B00 + i)});
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Push accepted while full because of a same-cycle pop.
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'(16'h1100 + i), 16'(16'h2200 + i), 1'b0, 1'b0);
    step(1'b1, 16'h5555, 16'hAAAA, 1'b1, 1'b0);
    check("fullpp_level", 32'(bus.level), 32'd4);
    check("fullpp_dc", 32'(bus.drop_count), 32'd0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("fullpp_last", {bus.out_l, bus.out_r}, 32'h5555AAAA);

    // Hold last popped sample when empty.
    step(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("hold_valid", 32'(bus.out_valid), 32'd0);
    check("hold_pair", {bus.out_l, bus.out_r}, 32'h7FFF8000);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("underflow_pair", {bus.out_l, bus.out_r}, 32'h7FFF8000);

    // Saturating drop counter, then clear colliding with a drop.
    for (int i = 0; i < 4 + 300; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    check("sat_dc", 32'(bus.drop_count), 32'd255);
    check("sat_ovf", 32'(bus.overflow), 32'd1);
    step(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b1);
    check("clrdrop_ovf", 32'(bus.overflow), 32'd1);
    check("clrdrop_dc", 32'(bus.drop_count), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("clr_dc", 32'(bus.drop_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 6), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 15) == 0));

    // Asynchronous reset between clock edges with three entries stored.
    while (q_m.size() != 0)
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'(16'h3300 + i), 16'(16'h4400 + i), 1'b0, 1'b0);
    check("pre_arst_level", 32'(bus.level), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_level", 32'(bus.level), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_l", 32'(bus.out_l), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
